// File: rtl/defs_div_sqrt_mvp.sv
// Shared div/sqrt definitions: format widths, precision-control width and the
// issue-side FSM state and request record.
package defs_div_sqrt_mvp;

   localparam int C_MANT_FP64 = 52;
   localparam int C_EXP_FP64  = 11;
   localparam int C_PC        = 6;

   localparam int C_MANT_W    = C_MANT_FP64 + 1;   // hidden bit included
   localparam int C_EXP_W     = C_EXP_FP64 + 1;
   localparam int C_MANT_Z_W  = C_MANT_FP64 + 5;   // prenormalized core result
   localparam int C_EXP_Z_W   = C_EXP_FP64 + 2;
   localparam int C_TAG_W_MAX = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      WAIT  = 2'd2,
      HOLD  = 2'd3
   } issue_state_e;

   typedef struct packed {
      logic                   op;
      logic [1:0]             fmt;
      logic [C_PC-1:0]        pc;
      logic [C_MANT_W-1:0]    mant_a;
      logic [C_MANT_W-1:0]    mant_b;
      logic [C_EXP_W-1:0]     exp_a;
      logic [C_EXP_W-1:0]     exp_b;
      logic                   spec_n;
      logic [C_TAG_W_MAX-1:0] tag;
   } req_t;

   localparam req_t REQ_RST = '{op: 1'b0, fmt: 2'b00, pc: '0, mant_a: '0, mant_b: '0,
                                exp_a: '0, exp_b: '0, spec_n: 1'b1, tag: '0};

endpackage

// File: rtl/div_sqrt_watchdog_mvp.sv
// Purpose: clearable cycle counter with an expiry compare for the issue watchdog.
// Latency: expired is combinational from the count; clear/increment take effect next cycle.
// Backpressure: none; counts only while en is high.
module div_sqrt_watchdog_mvp #(
   parameter int TIMEOUT_CYC = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC);

   logic [CNT_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   assign expired = (count == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/div_sqrt_issue_mvp.sv
// Purpose: issue-side initiator for the div/sqrt core: registers a request, strobes the core, captures the result.
// Latency: accept in cycle 0, Start in cycle 1; Done in cycle N gives Out_valid_SO in cycle N+1.
// Backpressure: In_ready_SO only in IDLE with core ready; response held in HOLD until Out_ready_SI.
module div_sqrt_issue_mvp
   import defs_div_sqrt_mvp::*;
#(
   parameter int TAG_W       = 4,
   parameter int TIMEOUT_CYC = 64
) (
   input  logic                  Clk_CI,
   input  logic                  Rst_RI,
   input  logic                  In_valid_SI,
   output logic                  In_ready_SO,
   input  logic                  Op_sqrt_SI,
   input  logic [1:0]            Format_sel_SI,
   input  logic [C_PC-1:0]       Precision_ctl_SI,
   input  logic [C_MANT_W-1:0]   Mant_a_DI,
   input  logic [C_MANT_W-1:0]   Mant_b_DI,
   input  logic [C_EXP_W-1:0]    Exp_a_DI,
   input  logic [C_EXP_W-1:0]    Exp_b_DI,
   input  logic                  Special_case_SBI,
   input  logic [TAG_W-1:0]      Tag_DI,
   input  logic                  Flush_SI,
   output logic                  Div_start_SO,
   output logic                  Sqrt_start_SO,
   output logic                  Start_SO,
   output logic                  Kill_SO,
   output logic                  Special_case_SBO,
   output logic                  Special_case_dly_SBO,
   output logic [C_PC-1:0]       Precision_ctl_SO,
   output logic [1:0]            Format_sel_SO,
   output logic [C_MANT_W-1:0]   Mant_a_DO,
   output logic [C_MANT_W-1:0]   Mant_b_DO,
   output logic [C_EXP_W-1:0]    Exp_a_DO,
   output logic [C_EXP_W-1:0]    Exp_b_DO,
   input  logic                  Ready_SI,
   input  logic                  Done_SI,
   input  logic [C_MANT_Z_W-1:0] Mant_z_DI,
   input  logic [C_EXP_Z_W-1:0]  Exp_z_DI,
   output logic                  Out_valid_SO,
   input  logic                  Out_ready_SI,
   output logic [C_MANT_Z_W-1:0] Mant_z_DO,
   output logic [C_EXP_Z_W-1:0]  Exp_z_DO,
   output logic [TAG_W-1:0]      Tag_DO,
   output logic                  Timeout_SO
);

   issue_state_e state, state_nxt;
   req_t         req_q;

   logic [C_MANT_Z_W-1:0] mant_z_q;
   logic [C_EXP_Z_W-1:0]  exp_z_q;
   logic                  timeout_q;
   logic                  spec_dly_q;

   logic accept;
   logic wd_clr;
   logic wd_en;
   logic wd_expired;
   logic done_take;
   logic expire_take;

   div_sqrt_watchdog_mvp #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_watchdog (
      .clk     (Clk_CI),
      .rst     (Rst_RI),
      .clr     (wd_clr),
      .en      (wd_en),
      .expired (wd_expired)
   );

   // Flush outranks Done and timeout; a flushed START suppresses Start so Kill never overlaps it.
   always_comb begin
      state_nxt     = state;
      In_ready_SO   = 1'b0;
      accept        = 1'b0;
      Start_SO      = 1'b0;
      Div_start_SO  = 1'b0;
      Sqrt_start_SO = 1'b0;
      Kill_SO       = 1'b0;
      Out_valid_SO  = 1'b0;
      wd_clr        = 1'b0;
      wd_en         = 1'b0;
      done_take     = 1'b0;
      expire_take   = 1'b0;
      unique case (state)
         IDLE: begin
            In_ready_SO = Ready_SI & ~Flush_SI;
            accept      = In_valid_SI & In_ready_SO;
            if (accept) state_nxt = START;
         end
         START: begin
            wd_clr = 1'b1;
            if (Flush_SI) begin
               Kill_SO   = 1'b1;
               state_nxt = IDLE;
            end else begin
               Start_SO      = 1'b1;
               Div_start_SO  = ~req_q.op;
               Sqrt_start_SO = req_q.op;
               state_nxt     = WAIT;
            end
         end
         WAIT: begin
            wd_en = 1'b1;
            if (Flush_SI) begin
               Kill_SO   = 1'b1;
               state_nxt = IDLE;
            end else if (Done_SI) begin
               done_take = 1'b1;
               state_nxt = HOLD;
            end else if (wd_expired) begin
               Kill_SO     = 1'b1;
               expire_take = 1'b1;
               state_nxt   = HOLD;
            end
         end
         HOLD: begin
            if (Flush_SI) begin
               state_nxt = IDLE;
            end else begin
               Out_valid_SO = 1'b1;
               if (Out_ready_SI) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge Clk_CI) begin
      if (Rst_RI) begin
         state      <= IDLE;
         req_q      <= REQ_RST;
         mant_z_q   <= '0;
         exp_z_q    <= '0;
         timeout_q  <= 1'b0;
         spec_dly_q <= 1'b1;
      end else begin
         state      <= state_nxt;
         spec_dly_q <= req_q.spec_n;
         if (accept) begin
            req_q <= '{op: Op_sqrt_SI, fmt: Format_sel_SI, pc: Precision_ctl_SI,
                       mant_a: Mant_a_DI, mant_b: Mant_b_DI,
                       exp_a: Exp_a_DI, exp_b: Exp_b_DI,
                       spec_n: Special_case_SBI, tag: C_TAG_W_MAX'(Tag_DI)};
         end
         if (done_take) begin
            mant_z_q  <= Mant_z_DI;
            exp_z_q   <= Exp_z_DI;
            timeout_q <= 1'b0;
         end else if (expire_take) begin
            mant_z_q  <= '0;
            exp_z_q   <= '0;
            timeout_q <= 1'b1;
         end
      end
   end

   if (TAG_W < C_TAG_W_MAX) begin : g_tag_pad
      logic tag_pad_unused;
      assign tag_pad_unused = |req_q.tag[C_TAG_W_MAX-1:TAG_W];
   end

   assign Special_case_SBO     = req_q.spec_n;
   assign Special_case_dly_SBO = spec_dly_q;
   assign Precision_ctl_SO     = req_q.pc;
   assign Format_sel_SO        = req_q.fmt;
   assign Mant_a_DO            = req_q.mant_a;
   assign Mant_b_DO            = req_q.mant_b;
   assign Exp_a_DO             = req_q.exp_a;
   assign Exp_b_DO             = req_q.exp_b;
   assign Mant_z_DO            = mant_z_q;
   assign Exp_z_DO             = exp_z_q;
   assign Tag_DO               = req_q.tag[TAG_W-1:0];
   assign Timeout_SO           = timeout_q;

endmodule

// File: doc/div_sqrt_issue_mvp.md
Name: div_sqrt_issue_mvp

Overview:
- Issue-side initiator for the iterative non-restoring div/sqrt core wrapper.
- Accepts one operation per transaction over a valid/ready request interface and registers the operands.
- Generates the core's start/kill/special-case strobes, waits for core Done, and captures the prenormalized mantissa/exponent.
- Returns the captured result on a valid/ready response interface, with a watchdog timeout and flush support.
- Sits between the FPU operation dispatcher and the core wrapper; the normalizer consumes the response.

Parameters:
- C_PC, 6: precision-control width; taken from the shared div/sqrt package.
- TAG_W, 4: width of the opaque transaction tag.
- TIMEOUT_CYC, 64: cycles allowed in WAIT before the watchdog fires; must be ≥ 2.

Ports:
- Clk_CI  in  1  clock.
- Rst_RI  in  1  reset; synchronous, active-high.
- In_valid_SI  in  1  request valid.
- In_ready_SO  out  1  request ready.
- Op_sqrt_SI  in  1  operation select: 1 = sqrt, 0 = div.
- Format_sel_SI  in  2  FP format select.
- Precision_ctl_SI  in  C_PC  precision control.
- Mant_a_DI / Mant_b_DI  in  53 each  operand mantissas, hidden bit included.
- Exp_a_DI / Exp_b_DI  in  12 each  operand exponents.
- Special_case_SBI  in  1  active-low; request is a special case.
- Tag_DI  in  TAG_W  request tag.
- Flush_SI  in  1  abort any in-flight operation.
- Div_start_SO / Sqrt_start_SO / Start_SO  out  1 each  core start strobes.
- Kill_SO  out  1  core kill strobe.
- Special_case_SBO / Special_case_dly_SBO  out  1 each  core special-case flag and its 1-cycle-delayed copy.
- Precision_ctl_SO  out  C_PC  to core.
- Format_sel_SO  out  2  to core.
- Mant_a_DO / Mant_b_DO  out  53 each  registered operands to core.
- Exp_a_DO / Exp_b_DO  out  12 each  registered operands to core.
- Ready_SI  in  1  core ready.
- Done_SI  in  1  core done.
- Mant_z_DI  in  57  core prenormalized mantissa.
- Exp_z_DI  in  13  core prenormalized exponent.
- Out_valid_SO  out  1  response valid.
- Out_ready_SI  in  1  response ready.
- Mant_z_DO  out  57  captured mantissa.
- Exp_z_DO  out  13  captured exponent.
- Tag_DO  out  TAG_W  captured tag.
- Timeout_SO  out  1  response carries a watchdog error.

Behaviour:
- Reset:
  - state = IDLE; all registers and outputs 0.
  - Special_case_SBO and Special_case_dly_SBO reset to 1 (inactive).
  - A reset mid-operation drops the transaction; no Kill_SO is issued (the core is reset by its own reset).
- FSM states: IDLE, START, WAIT, HOLD.
- IDLE:
  - In_ready_SO = Ready_SI & ~Flush_SI.
  - On handshake: capture op, format, precision, operands, special flag and tag; go to START.
- START (exactly 1 cycle):
  - Start_SO = 1.
  - Div_start_SO = ~op; Sqrt_start_SO = op.
  - Clear the watchdog counter; go to WAIT.
- Special_case_dly_SBO = Special_case_SBO registered by one cycle.
- Operand, format and precision outputs are driven from the registers continuously.
- WAIT:
  - Counter increments every cycle.
  - On Done_SI: capture Mant_z_DI, Exp_z_DI; Timeout flag = 0; go to HOLD.
  - Else if counter == TIMEOUT_CYC-1: Kill_SO = 1 for that cycle; result = 0; Timeout flag = 1; go to HOLD.
- HOLD:
  - Out_valid_SO = 1; outputs are stable until accepted.
  - On Out_ready_SI: go to IDLE.
  - No same-cycle re-accept, so the minimum issue interval is 4 cycles.
- Flush_SI:
  - In START or WAIT: Kill_SO = 1 that cycle; go to IDLE; no response.
  - In HOLD: drop the response; go to IDLE.
  - In IDLE: blocks acceptance.
  - Flush has priority over Done and timeout in the same cycle.
- Done_SI outside WAIT is ignored.
- Done_SI and timeout in the same cycle: Done wins, Timeout flag = 0.
- Latency: request accepted in cycle 0, Start in cycle 1; if Done arrives in cycle N, Out_valid_SO rises in cycle N+1.
- Kill_SO is never asserted together with Start_SO.

Decomposition:
- Shared package defs_div_sqrt_mvp supplies C_MANT_FP64 (52), C_EXP_FP64 (11) and C_PC (6).
- Add to that package an FSM state enum and a request struct {op, fmt, pc, mant_a, mant_b, exp_a, exp_b, spec_n, tag}.
- Sub-module: div_sqrt_watchdog_mvp, a clearable counter with an expiry compare.

Test Plan:
- FP32 div with core model Done after 12 cycles: Mant_a = 1.5 (bit52 = 1, bit51 = 1), Mant_b = 1.0, Exp_a = Exp_b = 127, tag 5 → Start_SO and Div_start_SO = 1 in cycle 1; Out_valid_SO in cycle 14 with the model's mantissa/exponent and Tag_DO = 5.
- Sqrt, FP64, Ready_SI = 0 for 3 cycles → In_ready_SO stays 0; accept after Ready_SI rises; Sqrt_start_SO = 1 and Div_start_SO = 0.
- Core never asserts Done, TIMEOUT_CYC = 8 → Kill_SO pulses exactly 1 cycle at WAIT count 7; response has Timeout_SO = 1 and Mant_z_DO = 0.
- Flush_SI in the 3rd WAIT cycle → Kill_SO pulse; no Out_valid_SO; next request is accepted normally.
- Out_ready_SI held 0 for 5 cycles in HOLD → outputs stable; In_ready_SO = 0 throughout; release → IDLE.
- Synchronous reset asserted mid-WAIT → next cycle all outputs at reset values; a Done_SI pulse arriving after reset produces no response.
